fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch queue that consumes the PC/instruction stream produced by the PC register and NPC logic and hands it to decode.
- Sits between IF and ID: buffers up to DEPTH fetched {PC, instruction} pairs and back-pressures the PC register through its write enable.
- Decouples fetch from decode stalls; discards all buffered entries on a branch/jump redirect (flush).

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- AW, 2, pointer width, equal to log2(DEPTH).
- NOP, 32'h00000013, instruction presented on dec_inst_o when the queue is empty (RISC-V addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- fetch_valid_i  input  1  pc_i/inst_i hold a valid fetched pair this cycle.
- pc_i  input  32  fetch address, from PCout.
- inst_i  input  32  instruction read from instruction memory at pc_i.
- PCwr  output  1  write enable to the PC register; high when the queue can accept and no flush is active.
- flush_i  input  1  redirect from branch resolution; discard all entries.
- dec_ready_i  input  1  decode accepts the head entry this cycle.
- dec_valid_o  output  1  head entry is valid.
- dec_pc_o  output  32  PC of the head entry.
- dec_pc4_o  output  32  dec_pc_o + 4, modulo 2^32.
- dec_inst_o  output  32  instruction of the head entry; NOP when empty.
- count_o  output  AW+1  current occupancy, 0..DEPTH.
- full_o  output  1  count_o == DEPTH.
- empty_o  output  1  count_o == 0.
- drop_cnt_o  output  8  saturating count of fetch_valid_i cycles rejected because the queue was full.

Behaviour:
- Storage: circular buffer of DEPTH entries of {pc, inst}. Registers wr_ptr and rd_ptr (AW bits, wrap modulo DEPTH) and count (AW+1 bits).
- push = fetch_valid_i & ~full_o & ~flush_i. A push writes the entry at wr_ptr, then wr_ptr increments.
- pop = dec_valid_o & dec_ready_i & ~flush_i. A pop increments rd_ptr.
- No full-bypass: when full, a push is rejected even if a pop occurs in the same cycle.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Output timing: outputs come combinationally from the entry at rd_ptr (first-word fall-through).
  - A pair pushed in cycle N appears on the outputs in cycle N+1 (latency 1).
  - An empty queue never passes the input straight through.
- dec_valid_o = ~empty_o.
- When empty: dec_inst_o = NOP, and dec_pc_o shows the stored value at rd_ptr.
- PCwr = ~full_o & ~flush_i, combinational. PCwr is independent of fetch_valid_i.
- flush_i (highest priority after rst): on the next edge wr_ptr, rd_ptr and count go to 0. Any push or pop in the flush cycle is ignored. drop_cnt_o is unaffected. The queue accepts pushes again from the cycle after flush_i deasserts.
- drop_cnt_o increments on each cycle with fetch_valid_i & full_o & ~flush_i, and saturates at 8'hFF.
- Reset: on a rising edge with rst=1, pointers, count, all storage and drop_cnt_o go to 0.
  - Outputs after reset: dec_valid_o=0, dec_pc_o=0, dec_pc4_o=4, dec_inst_o=NOP, count_o=0, empty_o=1, full_o=0, PCwr=1, drop_cnt_o=0.
  - Reset mid-operation drops all entries with no partial state.
- Pointer wrap: after DEPTH pushes wr_ptr returns to 0, and the entry order seen at the output is preserved across the wrap.
- Invariant: count_o always equals the number of accepted pushes minus pops since the last reset or flush.

Test Plan:
- Reset then idle (fetch_valid_i=0, dec_ready_i=0) -> dec_valid_o=0, dec_inst_o=32'h00000013, PCwr=1, count_o=0, drop_cnt_o=0.
- Single push pc_i=32'h10100100, inst_i=32'h00123400, dec_ready_i=0 -> the next cycle shows dec_valid_o=1, dec_pc_o=32'h10100100, dec_pc4_o=32'h10100104, count_o=1. Then pulse dec_ready_i -> empty_o=1.
- Push 4 entries (pc 0x100, 0x104, 0x108, 0x10C) with dec_ready_i=0 -> full_o=1, PCwr=0. A 5th fetch_valid_i -> drop_cnt_o=1, and the entry is not stored.
- Full queue with fetch_valid_i=1 and dec_ready_i=1 -> the cycle is pop-only, count goes 4 to 3, and the next cycle accepts a push. Pop order is 0x100, 0x104, 0x108, 0x10C, then the new entry.
- Fill 3 entries, then flush_i=1 with fetch_valid_i=1 and dec_ready_i=1 -> next cycle count_o=0, dec_valid_o=0, PCwr=1 after flush_i drops. The redirect target pc 0x2000 pushed next appears at the head.
- Continuous push/pop for 10 cycles with pc incrementing by 4 -> count_o stays at 1, pointers wrap, outputs stay in order. Assert rst mid-stream -> state is zero on the next edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID: a first-word fall-through circular buffer of {pc, inst} pairs.
// It back-pressures the PC register and is cleared whenever a branch or jump redirects fetch.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_valid_i,
  input  logic [31:0]   pc_i,
  input  logic [31:0]   inst_i,
  output logic          PCwr,
  input  logic          flush_i,
  input  logic          dec_ready_i,
  output logic          dec_valid_o,
  output logic [31:0]   dec_pc_o,
  output logic [31:0]   dec_pc4_o,
  output logic [31:0]   dec_inst_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [7:0]    drop_cnt_o
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    drop_cnt;
  logic          push;
  logic          pop;
  logic          drop;

  always_comb begin
    full_o      = (count == FULL_COUNT);
    empty_o     = (count == '0);
    dec_valid_o = ~empty_o;
    push        = fetch_valid_i & ~full_o & ~flush_i;
    pop         = dec_valid_o & dec_ready_i & ~flush_i;
    drop        = fetch_valid_i & full_o & ~flush_i;
    PCwr        = ~full_o & ~flush_i;
    count_o     = count;
    drop_cnt_o  = drop_cnt;
    dec_pc_o    = pc_mem[rd_ptr];
    dec_pc4_o   = dec_pc_o + 32'd4;
    dec_inst_o  = empty_o ? NOP : inst_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      pc_mem   <= '{default: '0};
      inst_mem <= '{default: '0};
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= pc_i;
        inst_mem[wr_ptr] <= inst_i;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      // Push is blocked when full, so count can only move by one step in either direction.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic.
// Expected values come from a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] inst_i = '0;
  logic        PCwr;
  logic        flush_i = 1'b0;
  logic        dec_ready_i = 1'b0;
  logic        dec_valid_o;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_pc4_o;
  logic [31:0] dec_inst_o;
  logic [AW:0] count_o;
  logic        full_o;
  logic        empty_o;
  logic [7:0]  drop_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] ref_q[$];
  int          ref_drop = 0;

  fetch_queue #(.DEPTH(DEPTH), .AW(AW), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .fetch_valid_i(fetch_valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .PCwr(PCwr), .flush_i(flush_i), .dec_ready_i(dec_ready_i), .dec_valid_o(dec_valid_o),
    .dec_pc_o(dec_pc_o), .dec_pc4_o(dec_pc4_o), .dec_inst_o(dec_inst_o), .count_o(count_o),
    .full_o(full_o), .empty_o(empty_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance the reference model at the edge, then return inputs to idle.
  task automatic cyc(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                     input logic fl, input logic rdy, input logic r);
    bit was_full;
    fetch_valid_i = fv; pc_i = pc; inst_i = inst; flush_i = fl; dec_ready_i = rdy; rst = r;
    @(posedge clk);
    was_full = (ref_q.size() == DEPTH);
    if (r) begin
      ref_q.delete();
      ref_drop = 0;
    end else if (fl) begin
      ref_q.delete();
    end else begin
      if (rdy && ref_q.size() > 0) void'(ref_q.pop_front());
      if (fv && !was_full) ref_q.push_back({pc, inst});
      if (fv && was_full && ref_drop < 255) ref_drop++;
    end
    #1;
    fetch_valid_i = 1'b0; flush_i = 1'b0; dec_ready_i = 1'b0; rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    cyc(1'b1, 32'hDEAD0000, 32'hBEEF0000, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    vectors++; if (dec_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", dec_valid_o); end
    vectors++; if (dec_inst_o !== NOP) begin miscompares++; $display("FAIL reset_inst got %h exp %h", dec_inst_o, NOP); end
    vectors++; if (PCwr !== 1'b1) begin miscompares++; $display("FAIL reset_pcwr got %b exp 1", PCwr); end
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count_o); end
    vectors++; if (drop_cnt_o !== 8'd0) begin miscompares++; $display("FAIL reset_drop got %0d exp 0", drop_cnt_o); end
    vectors++; if (dec_pc_o !== 32'd0 || dec_pc4_o !== 32'd4) begin miscompares++; $display("FAIL reset_pc got %h/%h exp 0/4", dec_pc_o, dec_pc4_o); end
    vectors++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin miscompares++; $display("FAIL reset_flags got e%b f%b exp e1 f0", empty_o, full_o); end
  endtask

  task automatic test_single;
    // Input presented but not yet clocked: the empty queue must not pass it through.
    fetch_valid_i = 1'b1; pc_i = 32'h10100100; inst_i = 32'h00123400;
    #2;
    vectors++; if (dec_valid_o !== 1'b0 || dec_inst_o !== NOP) begin miscompares++; $display("FAIL no_bypass got v%b %h exp v0 %h", dec_valid_o, dec_inst_o, NOP); end
    cyc(1'b1, 32'h10100100, 32'h00123400, 1'b0, 1'b0, 1'b0);
    vectors++; if (dec_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b exp 1", dec_valid_o); end
    vectors++; if (dec_pc_o !== 32'h10100100) begin miscompares++; $display("FAIL single_pc got %h exp 10100100", dec_pc_o); end
    vectors++; if (dec_pc4_o !== 32'h10100104) begin miscompares++; $display("FAIL single_pc4 got %h exp 10100104", dec_pc4_o); end
    vectors++; if (dec_inst_o !== 32'h00123400) begin miscompares++; $display("FAIL single_inst got %h exp 00123400", dec_inst_o); end
    vectors++; if (count_o !== 3'd1) begin miscompares++; $display("FAIL single_count got %0d exp 1", count_o); end
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    vectors++; if (empty_o !== 1'b1 || dec_inst_o !== NOP) begin miscompares++; $display("FAIL single_pop got e%b %h exp e1 %h", empty_o, dec_inst_o, NOP); end
  endtask

  task automatic test_fill_drop;
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h100 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
    vectors++; if (full_o !== 1'b1 || PCwr !== 1'b0) begin miscompares++; $display("FAIL fill_full got f%b pcwr%b exp f1 pcwr0", full_o, PCwr); end
    vectors++; if (count_o !== 3'd4) begin miscompares++; $display("FAIL fill_count got %0d exp 4", count_o); end
    cyc(1'b1, 32'h500, 32'h0BAD0BAD, 1'b0, 1'b0, 1'b0);
    vectors++; if (drop_cnt_o !== 8'd1) begin miscompares++; $display("FAIL drop_cnt got %0d exp 1", drop_cnt_o); end
    vectors++; if (count_o !== 3'd4 || dec_pc_o !== 32'h100) begin miscompares++; $display("FAIL drop_nostore got %0d %h exp 4 100", count_o, dec_pc_o); end
  endtask

  task automatic test_full_pop;
    logic [31:0] exp_pc [5];
    exp_pc = '{32'h104, 32'h108, 32'h10C, 32'h600, 32'h0};
    // Full with push and pop: pop only, and the rejected fetch counts as a drop.
    cyc(1'b1, 32'h600, 32'h00600600, 1'b0, 1'b1, 1'b0);
    vectors++; if (count_o !== 3'd3) begin miscompares++; $display("FAIL fullpop_count got %0d exp 3", count_o); end
    vectors++; if (drop_cnt_o !== 8'(ref_drop)) begin miscompares++; $display("FAIL fullpop_drop got %0d exp %0d", drop_cnt_o, ref_drop); end
    vectors++; if (dec_pc_o !== exp_pc[0]) begin miscompares++; $display("FAIL fullpop_head got %h exp %h", dec_pc_o, exp_pc[0]); end
    cyc(1'b1, 32'h600, 32'h00600600, 1'b0, 1'b1, 1'b0);
    vectors++; if (count_o !== 3'd3 || dec_pc_o !== exp_pc[1]) begin miscompares++; $display("FAIL pushpop got %0d %h exp 3 %h", count_o, dec_pc_o, exp_pc[1]); end
    for (int i = 2; i < 4; i++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      vectors++; if (dec_pc_o !== exp_pc[i]) begin miscompares++; $display("FAIL pop_order%0d got %h exp %h", i, dec_pc_o, exp_pc[i]); end
    end
    vectors++; if (dec_inst_o !== 32'h00600600) begin miscompares++; $display("FAIL pop_new_inst got %h exp 00600600", dec_inst_o); end
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL pop_drain got e%b exp 1", empty_o); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h700 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
    flush_i = 1'b1; fetch_valid_i = 1'b1; dec_ready_i = 1'b1;
    #1;
    vectors++; if (PCwr !== 1'b0) begin miscompares++; $display("FAIL flush_pcwr got %b exp 0", PCwr); end
    cyc(1'b1, 32'h800, 32'h00800800, 1'b1, 1'b1, 1'b0);
    vectors++; if (count_o !== 3'd0 || dec_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_clear got %0d v%b exp 0 v0", count_o, dec_valid_o); end
    vectors++; if (PCwr !== 1'b1) begin miscompares++; $display("FAIL flush_after_pcwr got %b exp 1", PCwr); end
    vectors++; if (drop_cnt_o !== 8'(ref_drop)) begin miscompares++; $display("FAIL flush_drop got %0d exp %0d", drop_cnt_o, ref_drop); end
    cyc(1'b1, 32'h2000, 32'h02000200, 1'b0, 1'b0, 1'b0);
    vectors++; if (dec_pc_o !== 32'h2000 || count_o !== 3'd1) begin miscompares++; $display("FAIL redirect_head got %h %0d exp 2000 1", dec_pc_o, count_o); end
  endtask

  task automatic test_stream;
    logic [31:0] pc;
    pc = 32'h3000;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, pc, pc ^ 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0);
      vectors++; if (count_o !== 3'd1) begin miscompares++; $display("FAIL stream_count%0d got %0d exp 1", i, count_o); end
      vectors++; if (dec_pc_o !== pc || dec_inst_o !== (pc ^ 32'hA5A5A5A5)) begin miscompares++; $display("FAIL stream_head%0d got %h %h exp %h", i, dec_pc_o, dec_inst_o, pc); end
      pc = pc + 32'd4;
    end
    cyc(1'b1, pc, '0, 1'b0, 1'b1, 1'b1);
    vectors++; if (count_o !== 3'd0 || dec_valid_o !== 1'b0 || dec_pc_o !== 32'd0 || drop_cnt_o !== 8'd0) begin
      miscompares++; $display("FAIL midrst got %0d v%b %h %0d exp 0 v0 0 0", count_o, dec_valid_o, dec_pc_o, drop_cnt_o); end
  endtask

  task automatic test_drop_sat;
    for (int i = 0; i < 4; i++)
      cyc(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++)
      cyc(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    vectors++; if (drop_cnt_o !== 8'hFF) begin miscompares++; $display("FAIL drop_sat got %0d exp 255", drop_cnt_o); end
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    logic [2:0] exp_cnt;
    logic [63:0] head;
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 16) == 0,
          ($urandom % 3) != 0, ($urandom % 97) == 0);
      exp_cnt = 3'(ref_q.size());
      vectors++; if (count_o !== exp_cnt) begin miscompares++; $display("FAIL rnd_count n%0d got %0d exp %0d", n, count_o, exp_cnt); end
      vectors++; if (full_o !== (exp_cnt == 3'd4) || empty_o !== (exp_cnt == 3'd0) || dec_valid_o !== (exp_cnt != 3'd0) || PCwr !== (exp_cnt != 3'd4)) begin
        miscompares++; $display("FAIL rnd_flags n%0d got f%b e%b v%b w%b cnt %0d", n, full_o, empty_o, dec_valid_o, PCwr, exp_cnt); end
      vectors++; if (drop_cnt_o !== 8'(ref_drop)) begin miscompares++; $display("FAIL rnd_drop n%0d got %0d exp %0d", n, drop_cnt_o, ref_drop); end
      if (ref_q.size() > 0) begin
        head = ref_q[0];
        vectors++; if (dec_pc_o !== head[63:32] || dec_pc4_o !== head[63:32] + 32'd4 || dec_inst_o !== head[31:0]) begin
          miscompares++; $display("FAIL rnd_head n%0d got %h %h %h exp %h", n, dec_pc_o, dec_pc4_o, dec_inst_o, head); end
      end else begin
        vectors++; if (dec_inst_o !== NOP) begin miscompares++; $display("FAIL rnd_nop n%0d got %h exp %h", n, dec_inst_o, NOP); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill_drop;
    test_full_pop;
    test_flush;
    test_stream;
    test_drop_sat;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
